bf_result_streamer: RTL and testbench
=====================================

BF_RESULT_STREAMER -- requirements
Module: bf_result_streamer

Interface
REQ-001 Parameter ADDR_W, default 13, Output Memory address width.
REQ-002 Parameter DATA_W, default 16, Output Memory word width.
REQ-003 Parameter MAX_ADDR, default 8191, last legal Output Memory address that may be read.
REQ-004 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-005 Port clock  input  1  rising-edge clock for all state.
REQ-006 Port reset  input  1  asynchronous active-high reset.
REQ-007 Port start  input  1  single-cycle request to stream Output Memory from address 0.
REQ-008 Port OMAR  output  ADDR_W  Output Memory read address.
REQ-009 Port OMDR  input  DATA_W  Output Memory read data; valid one cycle after OMAR is stable.
REQ-010 Port res_valid  output  1  res_data holds a valid word.
REQ-011 Port res_ready  input  1  downstream accepts the word.
REQ-012 Port res_data  output  DATA_W  streamed Output Memory word.
REQ-013 Port res_kind  output  2  word tag: 0 distance, 1 destination, 2 path node, 3 terminator.
REQ-014 Port res_sop / res_eop / res_last  output  1 each  first word of record / terminator word / terminator of final record.
REQ-015 Port busy  output  1  high from accepted start until return to IDLE.
REQ-016 Port done  output  1  one-cycle pulse on completion.
REQ-017 Port err_overflow  output  1  sticky; MAX_ADDR read without final terminator.
REQ-018 Port rec_count  output  8  records completed, saturating at 255.

Function
REQ-019 States: IDLE, WAIT, CAPT, EMIT, DONE.
REQ-020 Record layout in Output Memory: distance, destination, path node(s), terminator; terminator 16'hFFFF = another record follows, 16'h0000 = final record.
REQ-021 IDLE: start high at an edge -> OMAR<=0, busy<=1, err_overflow<=0, rec_count<=0, field position<=distance, go WAIT; start sampled only in IDLE, ignored otherwise.
REQ-022 WAIT -> CAPT unconditionally (one cycle memory latency).
REQ-023 CAPT: res_data<=OMDR, res_kind from field position, res_sop<=(kind==0), res_valid<=1, go EMIT.
REQ-024 Terminator detection only in path-node position: OMDR==16'hFFFF or 16'h0000 -> kind 3, res_eop<=1; res_last<=1 only for 16'h0000; distance/destination words never treated as terminators.
REQ-025 EMIT: res_valid, res_data, res_kind, res_sop, res_eop, res_last held stable while res_ready low.
REQ-026 EMIT with res_ready high: res_valid<=0; field position advances distance->destination->path; path stays path until terminator; after terminator position<=distance and rec_count increments (saturating).
REQ-027 EMIT handshake, not final terminator, OMAR<MAX_ADDR: OMAR<=OMAR+1, go WAIT.
REQ-028 EMIT handshake, final terminator: go DONE; handshake of non-final word at OMAR==MAX_ADDR: err_overflow<=1, go DONE, OMAR unchanged.
REQ-029 DONE: done<=1 for one cycle, busy<=0, go IDLE; err_overflow and rec_count hold until next accepted start.
REQ-030 Latency: start edge k -> res_valid first high after edge k+2; steady-state one word per 3 cycles with res_ready held high.
REQ-031 res_ready high outside EMIT has no effect; no word is dropped or duplicated.

Reset
REQ-032 reset high asynchronously forces IDLE, OMAR=0, res_valid=0, res_data=0, res_kind=0, res_sop=0, res_eop=0, res_last=0, busy=0, done=0, err_overflow=0, rec_count=0.
REQ-033 reset asserted mid-stream aborts without emitting further words; first start after release restarts at address 0.

Verification
REQ-034 Memory {0x0005,0x0003,0x0002,0x0001,0x0000}, start, ready=1 -> 5 words, kinds 0,1,2,2,3; sop on word 0; eop+last on word 4; rec_count=1; done one cycle; first res_valid 3 cycles after start.
REQ-035 Two records {0x0004,0x0002,0x0001,0xFFFF,0x0007,0x0003,0x0001,0x0000} -> eop without last at word 3, sop at word 4, eop+last at word 7, rec_count=2.
REQ-036 Backpressure: ready low 5 cycles on word 2 -> res_data/res_kind stable throughout, OMAR unchanged, word accepted exactly once.
REQ-037 Distance word 0x0000 at address 0 -> kind 0, not terminator, streaming continues.
REQ-038 No 0x0000 terminator through address MAX_ADDR -> err_overflow=1 after last handshake, done pulse, busy=0, OMAR=MAX_ADDR.
REQ-039 Reset asserted while res_valid=1 -> all outputs zero immediately; later start streams from address 0 again; start pulses while busy ignored.

Source files
------------

// File: rtl/bf_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bf_result_streamer_if
//  Brief    : Result word stream from the streamer to its downstream consumer.
//  Revision : 1.0
// ============================================================================
interface bf_result_streamer_if #(
    parameter int DATA_W = 16
);
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_kind;
    logic              res_sop;
    logic              res_eop;
    logic              res_last;

    modport master (
        output res_valid, res_data, res_kind, res_sop, res_eop, res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_kind, res_sop, res_eop, res_last,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/bf_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : bf_result_streamer
//  Brief    : Walks Output Memory from address 0 and streams tagged result words.
//  Revision : 1.0
// ============================================================================
module bf_result_streamer #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int MAX_ADDR = 8191
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              start,
    output logic [ADDR_W-1:0]      OMAR,
    input  wire logic [DATA_W-1:0] OMDR,
    bf_result_streamer_if.master   res,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overflow,
    output logic [7:0]             rec_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] c_POS_DIST = 2'd0;
    localparam logic [1:0] c_POS_DEST = 2'd1;
    localparam logic [1:0] c_POS_PATH = 2'd2;
    localparam logic [1:0] c_KIND_TERM = 2'd3;

    localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(MAX_ADDR);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_pos;
    logic [ADDR_W-1:0] r_omar;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_kind;
    logic              r_sop;
    logic              r_eop;
    logic              r_last;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_rec_count;

    logic w_start_ok;
    logic w_capture;
    logic w_accept;
    logic w_is_term;
    logic w_at_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_CAPT;
            S_CAPT: w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (res.res_ready) begin
                    w_state_nxt = (r_last || w_at_max) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Terminators are only recognised in path position, so distance or
    // destination values of 0x0000/0xFFFF pass through as ordinary words.
    always_comb begin
        w_start_ok = (r_state == S_IDLE) && start;
        w_capture  = (r_state == S_CAPT);
        w_accept   = (r_state == S_EMIT) && res.res_ready;
        w_is_term  = (r_pos == c_POS_PATH) && ((OMDR == {DATA_W{1'b1}}) || (OMDR == '0));
        w_at_max   = (r_omar == c_MAX_ADDR);
        busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pos       <= c_POS_DIST;
            r_omar      <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_kind      <= 2'd0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rec_count <= 8'd0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_start_ok) begin
                r_omar      <= '0;
                r_err       <= 1'b0;
                r_rec_count <= 8'd0;
                r_pos       <= c_POS_DIST;
            end
            if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= OMDR;
                r_kind  <= w_is_term ? c_KIND_TERM : r_pos;
                r_sop   <= !w_is_term && (r_pos == c_POS_DIST);
                r_eop   <= w_is_term;
                r_last  <= w_is_term && (OMDR == '0);
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                if (r_eop) begin
                    r_pos <= c_POS_DIST;
                    if (r_rec_count != 8'hFF) begin
                        r_rec_count <= r_rec_count + 8'd1;
                    end
                end else if (r_pos != c_POS_PATH) begin
                    r_pos <= r_pos + 2'd1;
                end
                if (!r_last) begin
                    if (w_at_max) begin
                        r_err <= 1'b1;
                    end else begin
                        r_omar <= r_omar + 1'b1;
                    end
                end
            end
        end
    end

    assign OMAR          = r_omar;
    assign res.res_valid = r_valid;
    assign res.res_data  = r_data;
    assign res.res_kind  = r_kind;
    assign res.res_sop   = r_sop;
    assign res.res_eop   = r_eop;
    assign res.res_last  = r_last;
    assign done          = r_done;
    assign err_overflow  = r_err;
    assign rec_count     = r_rec_count;

endmodule
`default_nettype wire

// File: tb/tb_bf_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf_result_streamer
//  Brief    : Directed, table-driven bench for bf_result_streamer.
//  Revision : 1.0
// ============================================================================
module tb_bf_result_streamer;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 16;
    localparam int MAX_ADDR = 31;

    typedef struct packed {
        logic [15:0] word;
        logic [1:0]  kind;
        logic        sop;
        logic        eop;
        logic        last;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] OMAR;
    logic [DATA_W-1:0] OMDR;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic [7:0]        rec_count;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    vec_t        tbl [0:16];
    int          n_tests = 0;
    int          n_fail  = 0;

    bf_result_streamer_if #(.DATA_W(DATA_W)) res_if ();

    bf_result_streamer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_ADDR(MAX_ADDR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .OMAR        (OMAR),
        .OMDR        (OMDR),
        .res         (res_if),
        .busy        (busy),
        .done        (done),
        .err_overflow(err_overflow),
        .rec_count   (rec_count)
    );

    always #5 clock = ~clock;

    // Output Memory: registered read, data one cycle after the address
    always @(posedge clock) OMDR <= mem[OMAR];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w, input logic [1:0] k,
                                input logic s, input logic e, input logic l);
        vec_t v;
        v.word = w; v.kind = k; v.sop = s; v.eop = e; v.last = l;
        return v;
    endfunction

    task automatic load_mem(input int first, input int n);
        for (int a = 0; a < 64; a++) mem[a] = 16'h1234;
        for (int i = 0; i < n; i++) mem[i] = tbl[first + i].word;
    endtask

    task automatic run_stream(input int first, input int n, input int stall_idx,
                              input bit poke_start, input int exp_rec);
        int cyc;
        int prev;
        int w;
        logic [15:0] hold_data;
        logic [1:0]  hold_kind;
        logic [ADDR_W-1:0] hold_addr;
        load_mem(first, n);
        res_if.res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc  = 1;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!res_if.res_valid && w < 20) begin
                tick(); cyc++; w++;
            end
            check($sformatf("valid w%0d", i), res_if.res_valid, 1);
            if (i == 0) check("latency", cyc, 3);
            else if (i != stall_idx + 1) check($sformatf("gap w%0d", i), cyc - prev, 3);
            prev = cyc;
            check($sformatf("data w%0d", i), res_if.res_data, tbl[first + i].word);
            check($sformatf("kind w%0d", i), res_if.res_kind, tbl[first + i].kind);
            check($sformatf("sop w%0d", i),  res_if.res_sop,  tbl[first + i].sop);
            check($sformatf("eop w%0d", i),  res_if.res_eop,  tbl[first + i].eop);
            check($sformatf("last w%0d", i), res_if.res_last, tbl[first + i].last);
            check($sformatf("busy w%0d", i), busy, 1);
            if (i == stall_idx) begin
                res_if.res_ready = 1'b0;
                hold_data = res_if.res_data;
                hold_kind = res_if.res_kind;
                hold_addr = OMAR;
                for (int s = 0; s < 5; s++) begin
                    tick(); cyc++;
                    check("stall valid", res_if.res_valid, 1);
                    check("stall data", res_if.res_data, hold_data);
                    check("stall kind", res_if.res_kind, hold_kind);
                    check("stall addr", OMAR, hold_addr);
                end
                res_if.res_ready = 1'b1;
            end
            if (poke_start && i == 1) start = 1'b1;
            tick(); cyc++;
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 10) begin
            check("no extra word", res_if.res_valid, 0);
            tick(); w++;
        end
        check("done pulse", done, 1);
        check("busy after done", busy, 0);
        check("rec_count", rec_count, exp_rec);
        check("err_overflow clear", err_overflow, 0);
        check("final addr", OMAR, n - 1);
        tick();
        check("done one cycle", done, 0);
    endtask

    initial begin
        int cnt;
        int w;
        // two-record stream and the single-record stream
        tbl[0]  = mk(16'h0005, 2'd0, 1, 0, 0);
        tbl[1]  = mk(16'h0003, 2'd1, 0, 0, 0);
        tbl[2]  = mk(16'h0002, 2'd2, 0, 0, 0);
        tbl[3]  = mk(16'h0001, 2'd2, 0, 0, 0);
        tbl[4]  = mk(16'h0000, 2'd3, 0, 1, 1);
        tbl[5]  = mk(16'h0004, 2'd0, 1, 0, 0);
        tbl[6]  = mk(16'h0002, 2'd1, 0, 0, 0);
        tbl[7]  = mk(16'h0001, 2'd2, 0, 0, 0);
        tbl[8]  = mk(16'hFFFF, 2'd3, 0, 1, 0);
        tbl[9]  = mk(16'h0007, 2'd0, 1, 0, 0);
        tbl[10] = mk(16'h0003, 2'd1, 0, 0, 0);
        tbl[11] = mk(16'h0001, 2'd2, 0, 0, 0);
        tbl[12] = mk(16'h0000, 2'd3, 0, 1, 1);
        tbl[13] = mk(16'h0000, 2'd0, 1, 0, 0);
        tbl[14] = mk(16'hFFFF, 2'd1, 0, 0, 0);
        tbl[15] = mk(16'h0002, 2'd2, 0, 0, 0);
        tbl[16] = mk(16'h0000, 2'd3, 0, 1, 1);

        reset = 1'b1;
        start = 1'b0;
        res_if.res_ready = 1'b0;
        load_mem(0, 0);
        tick(); tick();
        check("rst OMAR", OMAR, 0);
        check("rst valid", res_if.res_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err_overflow, 0);
        check("rst rec_count", rec_count, 0);
        reset = 1'b0;
        tick();

        run_stream(0, 5, -1, 0, 1);
        run_stream(5, 8, -1, 1, 2);
        run_stream(0, 5, 2, 0, 1);
        run_stream(13, 4, -1, 0, 1);

        // no final terminator anywhere up to MAX_ADDR
        for (int a = 0; a <= MAX_ADDR; a++) begin
            case (a % 4)
                0: mem[a] = 16'h0001;
                1: mem[a] = 16'h0002;
                2: mem[a] = 16'h0003;
                default: mem[a] = 16'hFFFF;
            endcase
        end
        res_if.res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        w = 0;
        while (!done && w < 400) begin
            if (res_if.res_valid) cnt++;
            tick(); w++;
        end
        check("ovf words", cnt, MAX_ADDR + 1);
        check("ovf done", done, 1);
        check("ovf err", err_overflow, 1);
        check("ovf busy", busy, 0);
        check("ovf OMAR", OMAR, MAX_ADDR);
        check("ovf rec_count", rec_count, (MAX_ADDR + 1) / 4);
        tick(); tick();
        check("ovf err sticky", err_overflow, 1);
        check("ovf rec hold", rec_count, (MAX_ADDR + 1) / 4);

        // a fresh start clears the sticky error
        run_stream(0, 5, -1, 0, 1);

        // reset while a word is pending
        load_mem(0, 5);
        res_if.res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!res_if.res_valid && w < 20) begin
            tick(); w++;
        end
        check("pre-reset valid", res_if.res_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async valid", res_if.res_valid, 0);
        check("async data", res_if.res_data, 0);
        check("async kind", res_if.res_kind, 0);
        check("async sop", res_if.res_sop, 0);
        check("async busy", busy, 0);
        check("async rec_count", rec_count, 0);
        tick(); tick();
        check("held reset valid", res_if.res_valid, 0);
        reset = 1'b0;
        tick();
        check("idle after reset", busy, 0);
        run_stream(0, 5, -1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
